// File: rtl/usb_cdc_xform_fifo.sv
// usb_cdc_xform_fifo: per-channel transforming byte FIFO between usb_cdc bulk OUT and bulk IN streams
module usb_cdc_xform_fifo #(
  parameter int CHANNELS = 1,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [8*CHANNELS-1:0]   s_data_i,
  input  logic [CHANNELS-1:0]     s_valid_i,
  output logic [CHANNELS-1:0]     s_ready_o,
  output logic [8*CHANNELS-1:0]   m_data_o,
  output logic [CHANNELS-1:0]     m_valid_o,
  input  logic [CHANNELS-1:0]     m_ready_i,
  input  logic [2*CHANNELS-1:0]   mode_i,
  input  logic [CHANNELS-1:0]     flush_i,
  output logic [CW*CHANNELS-1:0]  level_o
);
  localparam int PW = $clog2(DEPTH - 1);

  function automatic logic [7:0] xform(input logic [7:0] b, input logic [1:0] m);
    logic w_alpha;
    w_alpha = (b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A);
    return m == 2'd1 ? b + 8'd1 : m == 2'd2 ? (w_alpha ? b ^ 8'h20 : b) : m == 2'd3 ? ~b : b;
  endfunction

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [7:0]    r_mem [DEPTH-1];
    logic [PW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    logic          r_v;
    logic [7:0]    r_out;
    logic [CW-1:0] w_level;
    logic [7:0]    w_byte;
    logic          w_wr, w_pop, w_load, w_ram_rd, w_ram_wr;
    assign w_level  = r_cnt + CW'(r_v);
    assign w_byte   = xform(s_data_i[8*c +: 8], mode_i[2*c +: 2]);
    assign w_wr     = s_valid_i[c] && w_level != CW'(DEPTH) && !flush_i[c];
    assign w_pop    = r_v && m_ready_i[c] && !flush_i[c];
    // Output register refills whenever it is empty or being popped this cycle.
    assign w_load   = !r_v || w_pop;
    assign w_ram_rd = w_load && r_cnt != '0;
    // A write into an empty pipeline lands straight in the output register.
    assign w_ram_wr = w_wr && !(w_load && r_cnt == '0);
    always_ff @(posedge clk_i)
      if (w_ram_wr) r_mem[r_wp] <= w_byte;
    always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
        r_v   <= 1'b0;
        r_out <= '0;
      end else if (flush_i[c]) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
        r_v   <= 1'b0;
      end else begin
        if (w_ram_wr) r_wp <= r_wp == PW'(DEPTH - 2) ? '0 : r_wp + 1'b1;
        if (w_ram_rd) r_rp <= r_rp == PW'(DEPTH - 2) ? '0 : r_rp + 1'b1;
        r_cnt <= r_cnt + CW'(w_ram_wr) - CW'(w_ram_rd);
        if (w_load) begin
          r_v   <= w_ram_rd || w_wr;
          r_out <= w_ram_rd ? r_mem[r_rp] : w_wr ? w_byte : r_out;
        end
      end
    assign s_ready_o[c]          = w_level != CW'(DEPTH);
    assign m_valid_o[c]          = r_v;
    assign m_data_o[8*c +: 8]    = r_out;
    assign level_o[CW*c +: CW]   = w_level;
  end
endmodule
